// File: rtl/floor_request_latch.sv
// Call-request store and IDLE/UP/DN direction scheduler for an N-floor elevator.
// Optional macro REQ_EDGE_DETECT_EN: buttons latch on rising edges instead of levels. All outputs are levels; no handshake.
module floor_request_latch #(
  parameter int FLOORS = 4,
  parameter int FW     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] car_btn,
  input  logic [FLOORS-1:0] hall_up,
  input  logic [FLOORS-1:0] hall_dn,
  input  logic [FW-1:0]     floor,
  input  logic              door_open,
  output logic [FLOORS-1:0] car_req,
  output logic [FLOORS-1:0] up_req,
  output logic [FLOORS-1:0] dn_req,
  output logic [1:0]        dir,
  output logic [FW-1:0]     target,
  output logic              target_vld,
  output logic              pending
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DN   = 2'b10
  } dir_t;

  // Top floor has no up button, ground floor has no down button.
  localparam logic [FLOORS-1:0] UP_MASK  = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_MASK  = {{(FLOORS-1){1'b1}}, 1'b0};
  localparam logic [FW:0]       FLOORS_W = (FW+1)'(FLOORS);

  dir_t              state;
  dir_t              next_dir;
  logic [FW-1:0]     next_target;
  logic              next_vld;
  logic              floor_ok;
  logic [FLOORS-1:0] clr_hot;
  logic [FLOORS-1:0] car_set, up_set, dn_set;
  logic [FLOORS-1:0] up_clr, dn_clr;
  logic [FLOORS-1:0] any_req;
  logic              above, below, here;
  logic [FW-1:0]     up_tgt, dn_tgt;

  assign floor_ok = ({1'b0, floor} < FLOORS_W);

`ifdef REQ_EDGE_DETECT_EN
  logic [FLOORS-1:0] car_prev, up_prev, dn_prev;

  // History cleared in reset so a button held across release latches once.
  always_ff @(posedge clk) begin
    if (reset) begin
      car_prev <= '0;
      up_prev  <= '0;
      dn_prev  <= '0;
    end else begin
      car_prev <= car_btn;
      up_prev  <= hall_up;
      dn_prev  <= hall_dn;
    end
  end

  assign car_set = car_btn & ~car_prev;
  assign up_set  = hall_up & ~up_prev & UP_MASK;
  assign dn_set  = hall_dn & ~dn_prev & DN_MASK;
`else
  assign car_set = car_btn;
  assign up_set  = hall_up & UP_MASK;
  assign dn_set  = hall_dn & DN_MASK;
`endif

  always_comb begin
    clr_hot = '0;
    if (door_open && floor_ok) begin
      for (int f = 0; f < FLOORS; f++) begin
        if (FW'(f) == floor) clr_hot[f] = 1'b1;
      end
    end
  end

  // Hall calls are only answered when the car leaves in their direction.
  assign up_clr = (state != DN) ? clr_hot : '0;
  assign dn_clr = (state != UP) ? clr_hot : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      car_req <= '0;
      up_req  <= '0;
      dn_req  <= '0;
    end else begin
      car_req <= (car_req | car_set) & ~clr_hot;
      up_req  <= (up_req | up_set) & ~up_clr;
      dn_req  <= (dn_req | dn_set) & ~dn_clr;
    end
  end

  assign any_req = car_req | up_req | dn_req;
  assign pending = |any_req;

  // Descending scan leaves the lowest call above; ascending scan leaves the highest below.
  always_comb begin
    above  = 1'b0;
    below  = 1'b0;
    here   = 1'b0;
    up_tgt = '0;
    dn_tgt = '0;
    for (int f = FLOORS - 1; f >= 0; f--) begin
      if (any_req[f] && (FW'(f) > floor)) begin
        above  = 1'b1;
        up_tgt = FW'(f);
      end
    end
    for (int f = 0; f < FLOORS; f++) begin
      if (any_req[f] && (FW'(f) < floor)) begin
        below  = 1'b1;
        dn_tgt = FW'(f);
      end
      if (any_req[f] && (FW'(f) == floor)) here = 1'b1;
    end
  end

  always_comb begin
    next_dir = IDLE;
    case (state)
      DN:      next_dir = below ? DN : (above ? UP : IDLE);
      default: next_dir = above ? UP : (below ? DN : IDLE);
    endcase
    next_target = '0;
    next_vld    = 1'b0;
    case (next_dir)
      UP: begin
        next_target = up_tgt;
        next_vld    = 1'b1;
      end
      DN: begin
        next_target = dn_tgt;
        next_vld    = 1'b1;
      end
      default: begin
        if (here) begin
          next_target = floor;
          next_vld    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      target     <= '0;
      target_vld <= 1'b0;
    end else if (floor_ok) begin
      state      <= next_dir;
      target     <= next_target;
      target_vld <= next_vld;
    end
  end

  assign dir = state;

endmodule
